// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/arith ops, bit-serial shifts and optional shift-add multiply.
// Define ALU_ITER_MUL_EN to build the MUL/MULHU datapath; otherwise opcodes 11/12 report illegal.
module alu_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      func,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned CW  = SHW + 1;

  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_SLL   = 5'd6;
  localparam logic [4:0] OP_SRL   = 5'd7;
  localparam logic [4:0] OP_SRA   = 5'd8;
  localparam logic [4:0] OP_SLT   = 5'd9;
  localparam logic [4:0] OP_SLTU  = 5'd10;
`ifdef ALU_ITER_MUL_EN
  localparam logic [4:0] OP_MUL   = 5'd11;
  localparam logic [4:0] OP_MULHU = 5'd12;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef ALU_ITER_MUL_EN
    S_MUL   = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  state_t          state, state_d;
  logic            in_ready_d, out_valid_d, illegal_d;
  logic [XLEN-1:0] out_d;
  logic [4:0]      op, op_d;
  logic [XLEN-1:0] acc, acc_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] shifted;
  logic [SHW-1:0]  shamt;
`ifdef ALU_ITER_MUL_EN
  logic [2*XLEN-1:0] prod, prod_d, prod_step;
  logic [XLEN:0]     madd;
`endif

  assign shamt = src_b[SHW-1:0];

  // Single-cycle results, evaluated on the operands offered at acceptance
  always_comb begin
    alu_res = '0;
    case (func)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default: alu_res = '0;
    endcase
  end

  // One-bit shift step of the working register
  always_comb begin
    shifted = acc;
    case (op)
      OP_SLL:  shifted = {acc[XLEN-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, acc[XLEN-1:1]};
      default: shifted = {acc[XLEN-1], acc[XLEN-1:1]};
    endcase
  end

`ifdef ALU_ITER_MUL_EN
  // Shift-add step: conditionally add multiplicand to the high half, then shift right
  always_comb begin
    madd      = {1'b0, prod[2*XLEN-1:XLEN]} + {1'b0, (prod[0] ? acc : {XLEN{1'b0}})};
    prod_step = {madd, prod[XLEN-1:1]};
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state;
    out_d     = out;
    illegal_d = illegal;
    op_d      = op;
    acc_d     = acc;
    cnt_d     = cnt;
`ifdef ALU_ITER_MUL_EN
    prod_d    = prod;
`endif
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          op_d = func;
          case (func)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU: begin
              out_d     = alu_res;
              illegal_d = 1'b0;
              state_d   = S_DONE;
            end
            OP_SLL, OP_SRL, OP_SRA: begin
              illegal_d = 1'b0;
              if (shamt == '0) begin
                out_d   = src_a;
                state_d = S_DONE;
              end else begin
                acc_d   = src_a;
                cnt_d   = CW'(shamt);
                state_d = S_SHIFT;
              end
            end
`ifdef ALU_ITER_MUL_EN
            OP_MUL, OP_MULHU: begin
              illegal_d = 1'b0;
              acc_d     = src_a;
              prod_d    = {{XLEN{1'b0}}, src_b};
              cnt_d     = CW'(XLEN);
              state_d   = S_MUL;
            end
`endif
            default: begin
              out_d     = '0;
              illegal_d = 1'b1;
              state_d   = S_DONE;
            end
          endcase
        end
      end
      S_SHIFT: begin
        acc_d = shifted;
        cnt_d = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          out_d   = shifted;
          state_d = S_DONE;
        end
      end
`ifdef ALU_ITER_MUL_EN
      S_MUL: begin
        prod_d = prod_step;
        cnt_d  = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          out_d   = (op == OP_MUL) ? prod_step[XLEN-1:0] : prod_step[2*XLEN-1:XLEN];
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out       <= '0;
      illegal   <= 1'b0;
      op        <= '0;
      acc       <= '0;
      cnt       <= '0;
`ifdef ALU_ITER_MUL_EN
      prod      <= '0;
`endif
    end else begin
      state     <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out       <= out_d;
      illegal   <= illegal_d;
      op        <= op_d;
      acc       <= acc_d;
      cnt       <= cnt_d;
`ifdef ALU_ITER_MUL_EN
      prod      <= prod_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter (XLEN=32): directed vectors with literal expectations plus a per-cycle reference model.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  func = 5'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out;
  logic        illegal;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  alu_iter #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .func(func), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Spec-level result and latency for an accepted operation
  function automatic void model_calc(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic il, output int lat);
    int sh;
`ifdef ALU_ITER_MUL_EN
    logic [63:0] p;
    p = 64'(a) * 64'(b);
`endif
    sh  = int'(b[4:0]);
    r   = 32'd0;
    il  = 1'b0;
    lat = 1;
    case (f)
      5'd1:  r = a + b;
      5'd2:  r = a - b;
      5'd3:  r = a & b;
      5'd4:  r = a | b;
      5'd5:  r = a ^ b;
      5'd6:  begin r = a << sh; lat = sh + 1; end
      5'd7:  begin r = a >> sh; lat = sh + 1; end
      5'd8:  begin r = 32'($signed(a) >>> sh); lat = sh + 1; end
      5'd9:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd10: r = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_ITER_MUL_EN
      5'd11: begin r = p[31:0];  lat = 33; end
      5'd12: begin r = p[63:32]; lat = 33; end
`endif
      default: il = 1'b1;
    endcase
  endfunction

  // Reference model: 0 = idle, 1 = computing, 2 = result held
  int          m_state = 0;
  int          m_cnt = 0;
  logic [31:0] m_out = 32'd0;
  logic        m_ill = 1'b0;
  logic [31:0] m_pend = 32'd0;
  logic        m_pend_ill = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int lat;
    if (!rst_n) begin
      m_state = 0; m_cnt = 0; m_out = 32'd0; m_ill = 1'b0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          model_calc(func, src_a, src_b, m_pend, m_pend_ill, lat);
          m_cnt = lat - 1;
          if (m_cnt == 0) begin
            m_state = 2; m_out = m_pend; m_ill = m_pend_ill;
          end else m_state = 1;
        end
        1: begin
          m_cnt = m_cnt - 1;
          if (m_cnt == 0) begin
            m_state = 2; m_out = m_pend; m_ill = m_pend_ill;
          end
        end
        default: if (out_ready) m_state = 0;
      endcase
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (out_valid !== (m_state == 2) || in_ready !== (m_state == 0) || out !== m_out ||
          (out_valid === 1'b1 && illegal !== m_ill)) begin
        failures++;
        $display("FAIL cycle_model t=%0t: got valid=%b ready=%b out=%h ill=%b, want valid=%b ready=%b out=%h ill=%b",
                 $time, out_valid, in_ready, out, illegal, (m_state == 2), (m_state == 0), m_out, m_ill);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Offer one op, wait for the result, check it, optionally stall, then consume it
  task automatic run_op(input string name, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input logic exp_ill, input int exp_lat, input int hold);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; func = f; src_a = a; src_b = b; out_ready = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (out_valid !== 1'b1 && lat < 100);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({name, "_out"}, out, exp);
    check({name, "_illegal"}, 32'(illegal), 32'(exp_ill));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; func = 5'd1; src_a = 32'(i * 7 + 3); src_b = 32'h1111_0000;
      @(posedge clk); #1;
      check({name, "_hold"}, {out_valid, in_ready, out[29:0]}, {1'b1, 1'b0, exp[29:0]});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({name, "_release"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  typedef struct {
    string       name;
    logic [4:0]  f;
    logic [31:0] a, b, e;
    logic        il;
    int          lat;
  } vec_t;
  vec_t vq[$];

  task automatic add(input string n, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] e, input logic il, input int lat);
    vec_t v;
    v.name = n; v.f = f; v.a = a; v.b = b; v.e = e; v.il = il; v.lat = lat;
    vq.push_back(v);
  endtask

  initial begin
    bit saw_valid;
    add("add_wrap",  5'd1,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
    add("sub_wrap",  5'd2,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1);
    add("and",       5'd3,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1);
    add("or",        5'd4,  32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF, 1'b0, 1);
    add("slt",       5'd9,  32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0, 1);
    add("sltu",      5'd10, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 1'b0, 1);
    add("sra4",      5'd8,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1'b0, 5);
    add("sll0",      5'd6,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1'b0, 1);
    add("srl31",     5'd7,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 1'b0, 32);
    add("sll3",      5'd6,  32'h0000_0001, 32'hFFFF_FFE3, 32'h0000_0008, 1'b0, 4);
    add("nop",       5'd0,  32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 1);
    add("op31",      5'd31, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0000_0000, 1'b1, 1);
`ifdef ALU_ITER_MUL_EN
    add("mulhu",     5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
    add("mul",       5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 33);
`else
    add("mulhu_ill", 5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
    add("mul_ill",   5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1);
`endif

    #2 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    #1 check("reset_state", {28'd0, in_ready, out_valid, illegal, 1'b0}, 32'h8);
    check("reset_out", out, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vq[i]) run_op(vq[i].name, vq[i].f, vq[i].a, vq[i].b, vq[i].e, vq[i].il, vq[i].lat, 0);

    // Stalled consumer with fresh operands offered throughout
    run_op("stall_xor", 5'd5, 32'h0F0F_0000, 32'h00FF_00FF, 32'h0FF0_00FF, 1'b0, 1, 10);

    // Reset in the middle of a long operation
    @(posedge clk); #1;
    in_valid = 1'b1; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
`ifdef ALU_ITER_MUL_EN
    func = 5'd11;
`else
    func = 5'd6; src_a = 32'h0000_0001; src_b = 32'h0000_001F;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("abort_reset", {29'd0, out_valid, in_ready, illegal}, 32'h2);
    check("abort_out", out, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    check("abort_no_result", {31'd0, saw_valid}, 32'd0);
    run_op("xor_after_abort", 5'd5, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 1, 0);

    repeat (2) @(posedge clk);
    #1 chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the operand and result width; it must be a power of two, 8 or greater.
REQ-002 Derived constant SHW = log2(XLEN), default 5, SHALL set the shift-amount width.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  an operation is offered.
REQ-006 in_ready  out  1  the block accepts the offered operation.
REQ-007 func  in  5  opcode: NOP=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10, MUL=11, MULHU=12.
REQ-008 src_a, src_b  in  XLEN each  operands.
REQ-009 out_valid  out  1  result available.
REQ-010 out_ready  in  1  consumer takes the result.
REQ-011 out  out  XLEN  result.
REQ-012 illegal  out  1  the current result came from an unsupported opcode.

Function
REQ-013 States SHALL be IDLE, SHIFT, MUL and DONE; in_ready SHALL be 1 only in IDLE.
REQ-014 Acceptance SHALL occur only when in_valid and in_ready are both 1; the block SHALL capture func and operands on that edge.
REQ-015 While not in IDLE, in_valid and the operand inputs SHALL be ignored.
REQ-016 ADD, SUB, AND, OR, XOR, SLT (signed) and SLTU SHALL go IDLE to DONE, giving out_valid on the cycle after acceptance (latency 1).
REQ-017 ADD and SUB SHALL wrap modulo 2^XLEN; SLT and SLTU SHALL return 1 or 0, zero-extended.
REQ-018 SLL, SRL and SRA SHALL use shamt = src_b[SHW-1:0] and shift one bit per cycle in SHIFT.
REQ-019 A shift SHALL take latency shamt+1; shamt=0 SHALL go straight to DONE with out=src_a.
REQ-020 SRA SHALL replicate the sign bit on each step.
REQ-021 NOP and opcodes 13..31 SHALL produce out=0 and illegal=1 with latency 1; all other operations SHALL produce illegal=0.
REQ-022 In DONE, out_valid SHALL be 1, and out and illegal SHALL hold stable until out_ready=1.
REQ-023 On the edge where out_valid and out_ready are both 1, the block SHALL return to IDLE; there is no back-to-back acceptance in that cycle.
REQ-024 out SHALL show the last result, or 0 after reset, whenever out_valid=0.
REQ-025 A busy counter SHALL count iterations; it SHALL be SHW+1 bits wide and SHALL never wrap during an operation.

Reset
REQ-026 While rst_n=0, the block SHALL force state=IDLE, in_ready=1, out_valid=0, out=0, illegal=0, and clear all counters and accumulators.
REQ-027 Reset asserted mid-operation SHALL abort the operation without producing a result; no out_valid SHALL follow.
REQ-028 Reset deassertion SHALL be synchronised externally; the block SHALL accept input from the first edge after deassertion.

Configuration
REQ-029 With macro ALU_ITER_MUL_EN defined, MUL and MULHU SHALL run in state MUL as a shift-add with one multiplier bit per cycle, latency XLEN+1 cycles.
REQ-030 With ALU_ITER_MUL_EN defined, MUL SHALL return the low XLEN bits of the unsigned product and MULHU the high XLEN bits.
REQ-031 With ALU_ITER_MUL_EN defined, the product register SHALL be 2*XLEN bits wide.
REQ-032 Without ALU_ITER_MUL_EN, the MUL state and product logic SHALL be absent, and opcodes 11 and 12 SHALL behave as illegal per REQ-021.

Verification (XLEN=32)
REQ-033 ADD 0xFFFFFFFF + 0x00000001 -> out=0x00000000 one cycle after acceptance; SLT 0x80000000 vs 0x00000001 -> 1; SLTU with the same operands -> 0.
REQ-034 SRA 0x80000000 by src_b=0x00000024 (shamt 4) -> out=0xF8000000 at cycle 5.
REQ-035 SLL with shamt 0 -> out=src_a at latency 1.
REQ-036 out_ready held 0 for 10 cycles in DONE, with in_valid=1 and new operands applied -> out and out_valid stable, no new acceptance, in_ready=0; out_ready=1 -> IDLE on the next edge.
REQ-037 With ALU_ITER_MUL_EN: MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE at cycle 33; MUL with the same operands -> 0x00000001. Without the macro: MUL -> out=0 and illegal=1 at cycle 1.
REQ-038 rst_n pulsed low at cycle 10 of a MUL -> out_valid stays 0, in_ready=1 immediately; a subsequent XOR 0xA5A5A5A5 ^ 0xFFFFFFFF -> 0x5A5A5A5A.
